// File: rtl/data_logic_reg.sv
// Bitwise logic unit (OR/AND/XOR/NOR) feeding a DEPTH-entry result FIFO with a registered head.
// Optional delivered-result counter opCount is built only when DATA_LOGIC_REG_CNT_EN is defined.
module data_logic_reg #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [WIDTH-1:0]        dataIn1,
  input  logic [WIDTH-1:0]        dataIn2,
  input  logic [1:0]              mode,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [WIDTH-1:0]        dataOut,
  output logic [$clog2(DEPTH):0]  level
`ifdef DATA_LOGIC_REG_CNT_EN
  ,
  output logic [CNT_W-1:0]        opCount
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W == 0 || WIDTH == 0) begin : g_bad_param
    $error("data_logic_reg: DEPTH must be a power of two >= 2, WIDTH and CNT_W nonzero");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic [WIDTH-1:0] result_c, head_nxt;
  logic             push, pop;

  assign push = inValid & inReady;
  assign pop  = outValid & outReady;

  // Operation select; mode is captured with the operands when the beat is pushed.
  always_comb begin
    result_c = '0;
    case (mode)
      2'b00:   result_c = dataIn1 | dataIn2;
      2'b01:   result_c = dataIn1 & dataIn2;
      2'b10:   result_c = dataIn1 ^ dataIn2;
      default: result_c = ~(dataIn1 | dataIn2);
    endcase
  end

  // Next pointers, occupancy and head; a push landing on the new read slot bypasses into the head.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level;
    if (push) wr_ptr_nxt = PTR_W'(wr_ptr + 1'b1);
    if (pop)  rd_ptr_nxt = PTR_W'(rd_ptr + 1'b1);
    case ({push, pop})
      2'b10:   level_nxt = LVL_W'(level + 1'b1);
      2'b01:   level_nxt = LVL_W'(level - 1'b1);
      default: level_nxt = level;
    endcase
    head_nxt = mem[rd_ptr_nxt];
    if (push && (wr_ptr == rd_ptr_nxt)) head_nxt = result_c;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= result_c;
    end
  end

  // All handshake and status outputs are registered from next-state values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      outValid <= 1'b0;
      inReady  <= 1'b1;
      dataOut  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      level    <= level_nxt;
      outValid <= (level_nxt != '0);
      inReady  <= (level_nxt < LVL_W'(DEPTH));
      dataOut  <= head_nxt;
    end
  end

`ifdef DATA_LOGIC_REG_CNT_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)    opCount <= '0;
    else if (pop) opCount <= CNT_W'(opCount + 1'b1);
  end
`endif

endmodule

// File: tb/tb_data_logic_reg.sv
// Directed and randomized self-checking bench for data_logic_reg (narrow DEPTH=2 and wide 8-bit instances).
module tb_data_logic_reg;

  logic clk;
  logic rstN;

  logic       in_valid2, in_ready2, out_valid2, out_ready2;
  logic [1:0] a2, b2, mode2, data_out2;
  logic [1:0] level2;
`ifdef DATA_LOGIC_REG_CNT_EN
  logic [1:0] op_count2;
  logic [7:0] op_count8;
`endif

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] a8, b8, data_out8;
  logic [1:0] mode8;
  logic [2:0] level8;

  int n_total = 0;
  int n_bad   = 0;

  data_logic_reg #(.WIDTH(2), .DEPTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rstN(rstN), .inValid(in_valid2), .inReady(in_ready2),
    .dataIn1(a2), .dataIn2(b2), .mode(mode2), .outValid(out_valid2),
    .outReady(out_ready2), .dataOut(data_out2), .level(level2)
`ifdef DATA_LOGIC_REG_CNT_EN
    , .opCount(op_count2)
`endif
  );

  data_logic_reg #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut8 (
    .clk(clk), .rstN(rstN), .inValid(in_valid8), .inReady(in_ready8),
    .dataIn1(a8), .dataIn2(b8), .mode(mode8), .outValid(out_valid8),
    .outReady(out_ready8), .dataOut(data_out8), .level(level8)
`ifdef DATA_LOGIC_REG_CNT_EN
    , .opCount(op_count8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    case (m)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    #4;
    rstN = 1'b1;
  endtask

  logic [7:0] q[$];
  logic [1:0] seq[9];

  initial begin
    rstN = 1'b1;
    in_valid2 = 0; out_ready2 = 0; a2 = 0; b2 = 0; mode2 = 0;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; mode8 = 0;
    #2;
    do_reset();
    #1;
    check("rst_out_valid", 32'(out_valid2), 0);
    check("rst_level", 32'(level2), 0);
    check("rst_data_out", 32'(data_out2), 0);
    check("rst_in_ready", 32'(in_ready2), 1);
    tick();

    // Four modes, A=01 B=10, consumer always ready
    out_ready2 = 1; in_valid2 = 1; a2 = 2'b01; b2 = 2'b10;
    begin
      logic [1:0] exp_m [4];
      exp_m[0] = 2'b11; exp_m[1] = 2'b00; exp_m[2] = 2'b11; exp_m[3] = 2'b00;
      for (int m = 0; m < 4; m++) begin
        mode2 = 2'(m);
        tick();
        check($sformatf("mode%0d_valid", m), 32'(out_valid2), 1);
        check($sformatf("mode%0d_data", m), 32'(data_out2), 32'(exp_m[m]));
      end
    end
    in_valid2 = 0;
    tick();
    check("mode_drain_valid", 32'(out_valid2), 0);
    check("mode_drain_level", 32'(level2), 0);

    // Backpressure: fill DEPTH=2, third beat blocked until one pop
    out_ready2 = 0; in_valid2 = 1; mode2 = 2'b00; b2 = 2'b00;
    a2 = 2'b01; tick();
    check("bp_level1", 32'(level2), 1);
    check("bp_ready1", 32'(in_ready2), 1);
    a2 = 2'b10; tick();
    check("bp_level2", 32'(level2), 2);
    check("bp_ready2", 32'(in_ready2), 0);
    a2 = 2'b11; tick();
    check("bp_level_hold", 32'(level2), 2);
    check("bp_head_hold", 32'(data_out2), 2'b01);
    check("bp_valid_hold", 32'(out_valid2), 1);
    out_ready2 = 1; tick();
    check("bp_pop_level", 32'(level2), 1);
    check("bp_pop_ready", 32'(in_ready2), 1);
    check("bp_pop_head", 32'(data_out2), 2'b10);
    out_ready2 = 0; tick();
    check("bp_third_level", 32'(level2), 2);
    in_valid2 = 0; out_ready2 = 1; tick();
    check("bp_drain_head", 32'(data_out2), 2'b11);
    tick();
    check("bp_drain_empty", 32'(out_valid2), 0);
    check("bp_no_underflow", 32'(level2), 0);
    tick();
    check("bp_empty_ignore", 32'(level2), 0);

    // Steady push+pop at level 1 for 8 cycles
    for (int i = 0; i < 9; i++) seq[i] = 2'((i * 3 + 1) % 4);
    out_ready2 = 0; in_valid2 = 1; b2 = 2'b00; mode2 = 2'b00;
    a2 = seq[0]; tick();
    out_ready2 = 1;
    for (int i = 1; i < 9; i++) begin
      a2 = seq[i];
      tick();
      check($sformatf("pp_level_%0d", i), 32'(level2), 1);
      check($sformatf("pp_data_%0d", i), 32'(data_out2), 32'(seq[i]));
    end
    in_valid2 = 0; tick();
    check("pp_end_level", 32'(level2), 0);

    // Asynchronous reset with two entries buffered
    out_ready2 = 0; in_valid2 = 1; mode2 = 2'b00; b2 = 2'b00;
    a2 = 2'b01; tick();
    a2 = 2'b10; tick();
    in_valid2 = 0;
    #2 rstN = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid2), 0);
    check("arst_level", 32'(level2), 0);
    check("arst_ready", 32'(in_ready2), 1);
    check("arst_data", 32'(data_out2), 0);
    #1 rstN = 1'b1;
    in_valid2 = 1; a2 = 2'b01; b2 = 2'b01; mode2 = 2'b10;
    tick();
    in_valid2 = 0; out_ready2 = 1;
    check("post_rst_level", 32'(level2), 1);
    check("post_rst_data", 32'(data_out2), 2'b00);
    tick();
    check("post_rst_only_own", 32'(out_valid2), 0);
    out_ready2 = 0;

`ifdef DATA_LOGIC_REG_CNT_EN
    // Counter wraps at CNT_W=2
    do_reset();
    check("cnt_rst", 32'(op_count2), 0);
    begin
      logic [1:0] exp_c [6];
      exp_c[0] = 0; exp_c[1] = 1; exp_c[2] = 2; exp_c[3] = 3; exp_c[4] = 0; exp_c[5] = 1;
      in_valid2 = 1; out_ready2 = 1;
      for (int i = 0; i < 6; i++) begin
        tick();
        check($sformatf("cnt_%0d", i), 32'(op_count2), 32'(exp_c[i]));
      end
    end
    in_valid2 = 0; out_ready2 = 0;
`endif

    // Randomized 8-bit run against a scoreboard
    do_reset();
    tick();
    begin
      int accepted = 0;
      int cycles = 0;
      int n_pop = 0;
      while ((accepted < 1000 || q.size() != 0) && cycles < 20000) begin
        in_valid8  = (accepted < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
        a8         = 8'($urandom);
        b8         = 8'($urandom);
        mode8      = 2'($urandom);
        out_ready8 = ($urandom_range(0, 2) != 0);
        #1;
        if (out_valid8 && out_ready8) begin
          if (q.size() == 0) check("rnd_extra_pop", 32'(data_out8), 32'hFFFF_FFFF);
          else check($sformatf("rnd_data_%0d", n_pop), 32'(data_out8), 32'(q.pop_front()));
          n_pop++;
        end
        if (in_valid8 && in_ready8) begin
          q.push_back(model(a8, b8, mode8));
          accepted++;
        end
        tick();
        cycles++;
      end
      in_valid8 = 0; out_ready8 = 0;
      check("rnd_timeout", 32'(cycles < 20000), 1);
      check("rnd_pop_count", 32'(n_pop), 1000);
      check("rnd_final_level", 32'(level8), 0);
      check("rnd_final_valid", 32'(out_valid8), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
